// File: rtl/genesis_pad_pkg.sv
// Shared encodings for the Genesis multi-port pad reader: pad types,
// decoded-bit positions, burst phase count, FSM states and the classifier.
package genesis_pad_pkg;

    localparam logic [1:0] PAD_SMS  = 2'd0;
    localparam logic [1:0] PAD_3BTN = 2'd1;
    localparam logic [1:0] PAD_6BTN = 2'd2;
    localparam logic [1:0] PAD_ERR  = 2'd3;

    localparam int BIT_R = 0;
    localparam int BIT_L = 1;
    localparam int BIT_D = 2;
    localparam int BIT_U = 3;
    localparam int BIT_A = 4;
    localparam int BIT_B = 5;
    localparam int BIT_C = 6;
    localparam int BIT_S = 7;
    localparam int BIT_M = 8;
    localparam int BIT_X = 9;
    localparam int BIT_Y = 10;
    localparam int BIT_Z = 11;

    // Button groups as they become meaningful with each pad class.
    localparam logic [11:0] MASK_BASE = 12'h06F;  // U D L R B C
    localparam logic [11:0] MASK_AS   = 12'h090;  // A S
    localparam logic [11:0] MASK_XYZM = 12'hF00;  // M X Y Z

    localparam int NUM_PHASES = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_e;

    // Pad class from the three burst signatures.
    function automatic logic [1:0] classify_pad(input logic three,
                                                input logic six,
                                                input logic term);
        logic [1:0] t;
        if (!three)
            t = PAD_SMS;
        else if (!six)
            t = PAD_3BTN;
        else if (term)
            t = PAD_6BTN;
        else
            t = PAD_ERR;
        return t;
    endfunction

endpackage

// File: rtl/genesis_pad_decoder.sv
// Per-port capture, classification and decode for one Genesis pad.
// Optional GENPAD_DEBOUNCE_EN: outputs only follow a frame whose raw type and
// decode repeat the previous frame's raw values.
module genesis_pad_decoder
    import genesis_pad_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  pins,
    input  logic        strobe,
    input  logic [2:0]  phase,
    input  logic        commit,
    output logic [1:0]  pad_type,
    output logic [11:0] decoded
);

    logic [11:0] cap;
    logic        three;
    logic        six;
    logic        term;
    logic [1:0]  raw_type;
    logic [11:0] raw_dec;

    // Capture pin snapshots at the strobe of the phases that carry information.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap   <= '0;
            three <= 1'b0;
            six   <= 1'b0;
            term  <= 1'b0;
        end else if (strobe) begin
            case (phase)
                3'd0: begin
                    cap[BIT_U] <= ~pins[3];
                    cap[BIT_D] <= ~pins[2];
                    cap[BIT_L] <= ~pins[1];
                    cap[BIT_R] <= ~pins[0];
                    cap[BIT_B] <= ~pins[4];
                    cap[BIT_C] <= ~pins[5];
                end
                3'd1: begin
                    cap[BIT_A] <= ~pins[4];
                    cap[BIT_S] <= ~pins[5];
                    three      <= (pins[1:0] == 2'b00);
                end
                3'd5: six <= three && (pins[3:0] == 4'b0000);
                3'd6: begin
                    cap[BIT_Z] <= ~pins[3];
                    cap[BIT_Y] <= ~pins[2];
                    cap[BIT_X] <= ~pins[1];
                    cap[BIT_M] <= ~pins[0];
                end
                3'd7: term <= (pins[3:0] == 4'b1111);
                default: ;
            endcase
        end
    end

    // Mask the captured buttons down to what the detected pad class can report.
    always_comb begin
        raw_type = classify_pad(three, six, term);
        raw_dec  = cap & MASK_BASE;
        if (raw_type != PAD_SMS)
            raw_dec = raw_dec | (cap & MASK_AS);
        if (raw_type == PAD_6BTN)
            raw_dec = raw_dec | (cap & MASK_XYZM);
    end

`ifdef GENPAD_DEBOUNCE_EN
    logic [1:0]  hist_type;
    logic [11:0] hist_dec;

    // Publish only when this frame's raw result repeats the previous one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_type <= PAD_SMS;
            hist_dec  <= '0;
            pad_type  <= PAD_SMS;
            decoded   <= '0;
        end else if (commit) begin
            hist_type <= raw_type;
            hist_dec  <= raw_dec;
            if ((raw_type == hist_type) && (raw_dec == hist_dec)) begin
                pad_type <= raw_type;
                decoded  <= raw_dec;
            end
        end
    end
`else
    // Publish the raw result on every commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_type <= PAD_SMS;
            decoded  <= '0;
        end else if (commit) begin
            pad_type <= raw_type;
            decoded  <= raw_dec;
        end
    end
`endif

endmodule

// File: rtl/genesis_multipad_reader.sv
// Genesis multi-port pad reader: one shared SELECT burst of 8 phases, then a
// long idle so 6-button pads reset their counter. Each port is decoded by its
// own genesis_pad_decoder. GENPAD_DEBOUNCE_EN enables per-port debounce.
module genesis_multipad_reader
    import genesis_pad_pkg::*;
#(
    parameter int NUM_PADS           = 2,
    parameter int SELECT_HALF_PERIOD = 1000,
    parameter int READ_LATENCY       = 48,
    parameter int FRAME_IDLE         = 100000
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic [6*NUM_PADS-1:0]  iGENPAD,
    output logic                   oGENPAD_SELECT,
    output logic [2*NUM_PADS-1:0]  oGENPAD_TYPE,
    output logic [12*NUM_PADS-1:0] oGENPAD_DECODED,
    output logic                   oFRAME_VALID
);

    localparam int IDLE_W = $clog2(FRAME_IDLE) + 1;
    localparam int TICK_W = $clog2(SELECT_HALF_PERIOD) + 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(FRAME_IDLE - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SELECT_HALF_PERIOD - 1);
    localparam logic [TICK_W-1:0] TICK_READ  = TICK_W'(READ_LATENCY);
    localparam logic [2:0]        PHASE_LAST = 3'(NUM_PHASES - 1);

    logic [6*NUM_PADS-1:0] pad_meta;
    logic [6*NUM_PADS-1:0] pad_sync;
    state_e                state;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [TICK_W-1:0]     tick_cnt;
    logic [2:0]            phase;
    logic                  select_q;
    logic                  frame_valid_q;
    logic                  strobe;
    logic                  commit;

    // Two-flop synchroniser on every pad pin.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            pad_meta <= '1;
            pad_sync <= '1;
        end else begin
            pad_meta <= iGENPAD;
            pad_sync <= pad_meta;
        end
    end

    // Frame sequencer: idle gap, 8-phase select burst, one-cycle commit.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state         <= IDLE;
            idle_cnt      <= '0;
            tick_cnt      <= '0;
            phase         <= '0;
            select_q      <= 1'b1;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    select_q <= 1'b1;
                    if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= '0;
                        tick_cnt <= '0;
                        phase    <= '0;
                        state    <= SCAN;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (phase == PHASE_LAST) begin
                            phase    <= '0;
                            select_q <= 1'b1;
                            state    <= COMMIT;
                        end else begin
                            phase    <= phase + 1'b1;
                            // next phase is odd exactly when the current one is even
                            select_q <= phase[0];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    frame_valid_q <= 1'b1;
                    select_q      <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign strobe         = (state == SCAN) && (tick_cnt == TICK_READ);
    assign commit         = (state == COMMIT);
    assign oGENPAD_SELECT = select_q;
    assign oFRAME_VALID   = frame_valid_q;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        genesis_pad_decoder u_dec (
            .clk      (iCLK),
            .rst      (iRESET),
            .pins     (pad_sync[6*p +: 6]),
            .strobe   (strobe),
            .phase    (phase),
            .commit   (commit),
            .pad_type (oGENPAD_TYPE[2*p +: 2]),
            .decoded  (oGENPAD_DECODED[12*p +: 12])
        );
    end

endmodule

// File: tb/tb_genesis_multipad_reader.sv
// Directed bench for genesis_multipad_reader with behavioural SMS, 3-button,
// 6-button and faulty 6-button pad models on two ports.
module tb_genesis_multipad_reader;

    localparam int NP  = 2;
    localparam int SHP = 20;
    localparam int RL  = 8;
    localparam int FI  = 100;
`ifdef GENPAD_DEBOUNCE_EN
    localparam int NF = 2;
`else
    localparam int NF = 1;
`endif

    // pad modes
    localparam int M_NONE = 0;
    localparam int M_SMS  = 1;
    localparam int M_3B   = 2;
    localparam int M_6B   = 3;
    localparam int M_BAD  = 4;

    logic          iCLK = 1'b0;
    logic          iRESET = 1'b1;
    logic [6*NP-1:0]  iGENPAD;
    logic          sel;
    logic [2*NP-1:0]  ptype;
    logic [12*NP-1:0] dec;
    logic          fv;

    int          mode0 = M_NONE;
    int          mode1 = M_NONE;
    logic [11:0] btn0 = '0;
    logic [11:0] btn1 = '0;

    int   errors = 0;
    int   checks = 0;

    // pad-side half-phase counter, reset by a long select-high gap
    int   k = 0;
    int   hi_cnt = 0;
    logic sel_q = 1'b1;

    genesis_multipad_reader #(
        .NUM_PADS           (NP),
        .SELECT_HALF_PERIOD (SHP),
        .READ_LATENCY       (RL),
        .FRAME_IDLE         (FI)
    ) dut (
        .iCLK            (iCLK),
        .iRESET          (iRESET),
        .iGENPAD         (iGENPAD),
        .oGENPAD_SELECT  (sel),
        .oGENPAD_TYPE    (ptype),
        .oGENPAD_DECODED (dec),
        .oFRAME_VALID    (fv)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        sel_q <= sel;
        if (sel != sel_q) begin
            k      <= k + 1;
            hi_cnt <= 0;
        end else if (sel) begin
            if (hi_cnt > 2 * SHP)
                k <= 0;
            else
                hi_cnt <= hi_cnt + 1;
        end
    end

    // b is active-high {Z,Y,X,M,S,C,B,A,U,D,L,R}; result is active-low pins
    function automatic logic [5:0] pad_pins(input int mode, input logic [11:0] b, input int kk);
        logic [5:0] hi;
        logic [5:0] lo;
        logic [5:0] r;
        hi = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
        lo = {~b[7], ~b[4], ~b[3], ~b[2], 2'b00};
        case (mode)
            M_SMS: r = hi;
            M_3B:  r = kk[0] ? lo : hi;
            M_6B, M_BAD: begin
                if (kk == 5)
                    r = {~b[7], ~b[4], 4'b0000};
                else if (kk == 6)
                    r = ~{b[6], b[5], b[11], b[10], b[9], b[8]};
                else if (kk == 7)
                    r = (mode == M_6B) ? {~b[7], ~b[4], 4'b1111} : {~b[7], ~b[4], 4'b0000};
                else
                    r = kk[0] ? lo : hi;
            end
            default: r = 6'b111111;
        endcase
        return r;
    endfunction

    assign iGENPAD = {pad_pins(mode1, btn1, k), pad_pins(mode0, btn0, k)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_commit(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge iCLK);
            if (fv) seen = 1'b1;
        end
        check({tag, "_commit"}, 32'(seen), 32'd1);
    endtask

    task automatic run_frames(input string tag);
        for (int i = 0; i < NF; i++) wait_commit(tag);
    endtask

    task automatic check_ports(input string tag, input logic [1:0] t0, input logic [11:0] d0,
                               input logic [1:0] t1, input logic [11:0] d1);
        check({tag, "_type0"}, 32'(ptype[1:0]), 32'(t0));
        check({tag, "_dec0"},  32'(dec[11:0]),  32'(d0));
        check({tag, "_type1"}, 32'(ptype[3:2]), 32'(t1));
        check({tag, "_dec1"},  32'(dec[23:12]), 32'(d1));
    endtask

    task automatic wait_k(input int target);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge iCLK);
            if (k == target) hit = 1'b1;
        end
        check("wait_k", 32'(hit), 32'd1);
    endtask

    initial begin
        int cyc;
        int fv_cnt;
        logic fell;

        // reset state
        repeat (3) @(negedge iCLK);
        check("rst_sel", 32'(sel), 32'd1);
        check("rst_fv", 32'(fv), 32'd0);
        check_ports("rst", 2'd0, 12'h000, 2'd0, 12'h000);

        // 6-button A+Z on port 0, nothing on port 1
        mode0 = M_6B; btn0 = 12'h810;
        mode1 = M_NONE; btn1 = 12'h000;
        iRESET = 1'b0;
        run_frames("six");
        check_ports("six", 2'd2, 12'h810, 2'd0, 12'h000);
        @(negedge iCLK);
        check("fv_width", 32'(fv), 32'd0);

        // 3-button Start on port 1; outputs must hold until the next commit
        mode0 = M_NONE; btn0 = 12'h000;
        mode1 = M_3B;   btn1 = 12'h080;
        wait_k(3);
        check_ports("hold", 2'd2, 12'h810, 2'd0, 12'h000);
        run_frames("three");
        check_ports("three", 2'd0, 12'h000, 2'd1, 12'h080);

        // SMS pads: Up+B on port 0, Up+C+S+A on port 1 (S, A invisible)
        mode0 = M_SMS; btn0 = 12'h028;
        mode1 = M_SMS; btn1 = 12'h0D8;
        run_frames("sms");
        check_ports("sms", 2'd0, 12'h028, 2'd0, 12'h048);

        // faulty 6-button on port 0, good 6-button with XYZM+R on port 1
        mode0 = M_BAD; btn0 = 12'hA18;
        mode1 = M_6B;  btn1 = 12'hF01;
        run_frames("err");
        check_ports("err", 2'd3, 12'h018, 2'd2, 12'hF01);

        // reset during phase 5
        wait_k(5);
        iRESET = 1'b1;
        #1;
        check("mid_rst_sel", 32'(sel), 32'd1);
        check("mid_rst_fv", 32'(fv), 32'd0);
        check_ports("mid_rst", 2'd0, 12'h000, 2'd0, 12'h000);
        fv_cnt = 0;
        repeat (4) begin
            @(negedge iCLK);
            if (fv) fv_cnt++;
        end
        iRESET = 1'b0;
        cyc = 0;
        fell = 1'b0;
        for (int c = 1; c <= 400 && !fell; c++) begin
            @(posedge iCLK);
            #1;
            if (fv) fv_cnt++;
            if (!sel) begin
                fell = 1'b1;
                cyc  = c;
            end
        end
        check("restart_fall", 32'(cyc), 32'(FI + SHP));
        check("restart_no_fv", 32'(fv_cnt), 32'd0);
        check_ports("restart_idle", 2'd0, 12'h000, 2'd0, 12'h000);
        run_frames("restart");
        check_ports("restart", 2'd3, 12'h018, 2'd2, 12'hF01);

`ifdef GENPAD_DEBOUNCE_EN
        // C toggling every frame never reaches the output; holding it does
        mode0 = M_NONE; btn0 = 12'h000;
        mode1 = M_3B;   btn1 = 12'h000;
        run_frames("db_base");
        check_ports("db_base", 2'd0, 12'h000, 2'd1, 12'h000);
        for (int i = 0; i < 4; i++) begin
            btn1 = (i % 2 == 0) ? 12'h040 : 12'h000;
            wait_commit("db_toggle");
            check("db_toggle_dec1", 32'(dec[23:12]), 32'h000);
        end
        btn1 = 12'h040;
        wait_commit("db_hold1");
        check("db_hold1_dec1", 32'(dec[23:12]), 32'h000);
        wait_commit("db_hold2");
        check("db_hold2_dec1", 32'(dec[23:12]), 32'h040);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
